// File: rtl/asrv32_timer_bridge.sv
// asrv32_timer_bridge: bus-mapped machine timer / MSIP register window.
// Turns 32-bit stores into 64-bit commit pulses toward the CSR unit and keeps
// shadow copies of mtime/mtimecmp so loads return coherent values.
module asrv32_timer_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLK_FREQ_MHZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wsel,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_mtime_wr_en,
  output logic        o_mtimecmp_wr_en,
  output logic [63:0] o_mtime_din,
  output logic [63:0] o_mtimecmp_din,
  output logic        o_software_interrupt,
  output logic        o_timer_pending
);

  // Last value of the millisecond prescaler before it wraps and mtime ticks.
  localparam logic [31:0] MS_LAST = 32'((CLK_FREQ_MHZ * 1000000) / 1000 - 1);

  localparam logic [4:0] OFF_MSIP   = 5'h00;
  localparam logic [4:0] OFF_CMP_LO = 5'h08;
  localparam logic [4:0] OFF_CMP_HI = 5'h0C;
  localparam logic [4:0] OFF_MT_LO  = 5'h10;
  localparam logic [4:0] OFF_MT_HI  = 5'h14;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] ms_cnt;
  logic [31:0] mt_stage;
  logic [31:0] cmp_stage;
  logic        mt_staged;
  logic        cmp_staged;
  logic [31:0] mt_snap;
  logic        last_lo_rd;
  logic        msip;
  logic [31:0] rd_val;

  logic hit, rd, wr, full, tick;
  logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  logic [63:0] mtime_new, cmp_new;

  assign hit        = (i_addr[31:5] == BASE_ADDR[31:5]);
  assign sel_msip   = hit && (i_addr[4:0] == OFF_MSIP);
  assign sel_cmp_lo = hit && (i_addr[4:0] == OFF_CMP_LO);
  assign sel_cmp_hi = hit && (i_addr[4:0] == OFF_CMP_HI);
  assign sel_mt_lo  = hit && (i_addr[4:0] == OFF_MT_LO);
  assign sel_mt_hi  = hit && (i_addr[4:0] == OFF_MT_HI);
  assign rd         = i_stb && !i_we;
  assign wr         = i_stb && i_we;
  assign full       = (i_wsel == 4'hF);
  assign tick       = (ms_cnt == MS_LAST);

  // A HI store commits the staged LO half if present, else keeps the live LO.
  assign mtime_new = {i_wdata, mt_staged ? mt_stage : mtime[31:0]};
  assign cmp_new   = {i_wdata, cmp_staged ? cmp_stage : mtimecmp[31:0]};

  assign o_software_interrupt = msip;
  assign o_timer_pending      = (mtime >= mtimecmp);

  // Load data mux; MTIME_HI returns the snapshot only right after an MTIME_LO load.
  always_comb begin
    rd_val = '0;
    if (sel_msip)   rd_val = {31'b0, msip};
    if (sel_cmp_lo) rd_val = mtimecmp[31:0];
    if (sel_cmp_hi) rd_val = mtimecmp[63:32];
    if (sel_mt_lo)  rd_val = mtime[31:0];
    if (sel_mt_hi)  rd_val = last_lo_rd ? mt_snap : mtime[63:32];
  end

  // Bus response, read snapshot and MSIP register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ack      <= 1'b0;
      o_rdata    <= '0;
      mt_snap    <= '0;
      last_lo_rd <= 1'b0;
      msip       <= 1'b0;
    end else begin
      o_ack <= i_stb;
      if (i_stb) begin
        last_lo_rd <= rd && sel_mt_lo;
        o_rdata    <= rd ? rd_val : 32'h0;
        if (rd && sel_mt_lo) mt_snap <= mtime[63:32];
        if (wr && sel_msip && i_wsel[0]) msip <= i_wdata[0];
      end
    end
  end

  // Shadow mtime with millisecond prescaler; a commit beats a same-cycle tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime         <= '0;
      ms_cnt        <= '0;
      mt_stage      <= '0;
      mt_staged     <= 1'b0;
      o_mtime_wr_en <= 1'b0;
      o_mtime_din   <= '0;
    end else begin
      o_mtime_wr_en <= 1'b0;
      if (wr && sel_mt_lo && full) begin
        mt_stage  <= i_wdata;
        mt_staged <= 1'b1;
      end
      if (wr && sel_mt_hi && full) begin
        o_mtime_wr_en <= 1'b1;
        o_mtime_din   <= mtime_new;
        mtime         <= mtime_new;
        ms_cnt        <= '0;
        mt_staged     <= 1'b0;
      end else if (tick) begin
        ms_cnt <= '0;
        mtime  <= mtime + 64'd1;
      end else begin
        ms_cnt <= ms_cnt + 32'd1;
      end
    end
  end

  // Shadow mtimecmp with LO staging and commit pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtimecmp         <= '0;
      cmp_stage        <= '0;
      cmp_staged       <= 1'b0;
      o_mtimecmp_wr_en <= 1'b0;
      o_mtimecmp_din   <= '0;
    end else begin
      o_mtimecmp_wr_en <= 1'b0;
      if (wr && sel_cmp_lo && full) begin
        cmp_stage  <= i_wdata;
        cmp_staged <= 1'b1;
      end
      if (wr && sel_cmp_hi && full) begin
        o_mtimecmp_wr_en <= 1'b1;
        o_mtimecmp_din   <= cmp_new;
        mtimecmp         <= cmp_new;
        cmp_staged       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_asrv32_timer_bridge.sv
// Self-checking bench for asrv32_timer_bridge (1 MHz build: 1000 cycles per mtime tick).
module tb_asrv32_timer_bridge;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wsel;
  logic        ack;
  logic [31:0] rdata;
  logic        mt_wr_en;
  logic        cmp_wr_en;
  logic [63:0] mt_din;
  logic [63:0] cmp_din;
  logic        sw_int;
  logic        pending;

  int n_checks = 0;
  int n_errors = 0;
  int n_mt_pulse = 0;
  int n_cmp_pulse = 0;

  // Scoreboard: bit 32 = compare rdata, bits 31:0 = expected rdata.
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  asrv32_timer_bridge #(
    .BASE_ADDR   (BASE),
    .CLK_FREQ_MHZ(1)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_stb               (stb),
    .i_we                (we),
    .i_addr              (addr),
    .i_wdata             (wdata),
    .i_wsel              (wsel),
    .o_ack               (ack),
    .o_rdata             (rdata),
    .o_mtime_wr_en       (mt_wr_en),
    .o_mtimecmp_wr_en    (cmp_wr_en),
    .o_mtime_din         (mt_din),
    .o_mtimecmp_din      (cmp_din),
    .o_software_interrupt(sw_int),
    .o_timer_pending     (pending)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: count commit pulses and pop the scoreboard on every ack.
  always @(negedge clk) begin
    if (mt_wr_en === 1'b1) n_mt_pulse++;
    if (cmp_wr_en === 1'b1) n_cmp_pulse++;
    if (ack === 1'b1) begin
      chk("ack_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if (e[32]) chk("rdata", 64'(rdata), 64'(e[31:0]));
      end
    end
  end

  // One strobe cycle; ack must be visible right after the sampling edge.
  task automatic xfer(input logic w, input logic [4:0] off, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_ack);
    stb = 1'b1; we = w; addr = BASE | 32'(off); wdata = d; wsel = s;
    if (exp_ack) exp_q.push_back({!w, exp_rd});
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; wsel = 4'h0;
    chk("ack_timing", 64'(ack), 64'(exp_ack));
  endtask

  task automatic wr32(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s);
    xfer(1'b1, off, d, s, 32'h0, 1'b1);
  endtask

  task automatic rd32(input logic [4:0] off, input logic [31:0] exp_rd);
    xfer(1'b0, off, 32'h0, 4'h0, exp_rd, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; wsel = '0;
    idle(3);
    rst = 1'b0;

    // Reset state and first reads.
    chk("pending_rst", 64'(pending), 64'd1);
    chk("swint_rst", 64'(sw_int), 64'd0);
    rd32(5'h10, 32'h0);
    rd32(5'h14, 32'h0);
    rd32(5'h08, 32'h0);

    // mtimecmp commit through LO staging; staged LO invisible before commit.
    wr32(5'h08, 32'h0000_1000, 4'hF);
    rd32(5'h08, 32'h0);
    wr32(5'h0C, 32'h0000_0002, 4'hF);
    chk("cmp_wr_en_pulse", 64'(cmp_wr_en), 64'd1);
    chk("cmp_din", cmp_din, 64'h0000_0002_0000_1000);
    idle(1);
    chk("cmp_wr_en_low", 64'(cmp_wr_en), 64'd0);
    chk("cmp_din_hold", cmp_din, 64'h0000_0002_0000_1000);
    rd32(5'h0C, 32'h2);
    rd32(5'h08, 32'h0000_1000);
    idle(1);
    chk("cmp_pulses", 64'(n_cmp_pulse), 64'd1);
    chk("pending_cmp", 64'(pending), 64'd0);

    // mtime: set to 7, then HI-only write keeps live LO; partial write ignored.
    wr32(5'h10, 32'h7, 4'hF);
    wr32(5'h14, 32'h0, 4'hF);
    wr32(5'h14, 32'h5, 4'hF);
    chk("mt_wr_en_pulse", 64'(mt_wr_en), 64'd1);
    chk("mt_din_hi_only", mt_din, 64'h0000_0005_0000_0007);
    idle(1);
    chk("mt_wr_en_low", 64'(mt_wr_en), 64'd0);
    wr32(5'h10, 32'h0000_AAAA, 4'h3);
    idle(2);
    chk("mt_pulses_partial", 64'(n_mt_pulse), 64'd2);
    chk("mt_din_partial", mt_din, 64'h0000_0005_0000_0007);
    rd32(5'h10, 32'h7);
    rd32(5'h14, 32'h5);

    // Tick across the 32-bit boundary.
    wr32(5'h10, 32'hFFFF_FFFF, 4'hF);
    wr32(5'h14, 32'h0, 4'hF);
    idle(1000);
    rd32(5'h10, 32'h0);
    rd32(5'h14, 32'h1);

    // Tick between LO and HI reads: HI returns the snapshot, later HI is live.
    wr32(5'h10, 32'hFFFF_FFFF, 4'hF);
    wr32(5'h14, 32'h0, 4'hF);
    idle(999);
    rd32(5'h10, 32'hFFFF_FFFF);
    rd32(5'h14, 32'h0);
    rd32(5'h14, 32'h1);
    idle(1);
    chk("mt_pulses_total", 64'(n_mt_pulse), 64'd4);
    chk("pending_after_tick", 64'(pending), 64'd0);

    // MSIP.
    wr32(5'h00, 32'h1, 4'h1);
    chk("msip_set", 64'(sw_int), 64'd1);
    wr32(5'h00, 32'h0, 4'h1);
    chk("msip_clr", 64'(sw_int), 64'd0);
    wr32(5'h00, 32'h1, 4'h2);
    chk("msip_wsel_ignored", 64'(sw_int), 64'd0);
    wr32(5'h00, 32'h1, 4'h1);

    // Back-to-back strobes.
    rd32(5'h00, 32'h1);
    rd32(5'h1C, 32'h0);
    rd32(5'h08, 32'h0000_1000);
    idle(1);

    // Reset lands on the second of three strobes: no further acks.
    rd32(5'h00, 32'h1);
    rst = 1'b1;
    xfer(1'b0, 5'h1C, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(1'b0, 5'h08, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(1);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mt_wr_en", 64'(mt_wr_en), 64'd0);
    chk("rst_cmp_wr_en", 64'(cmp_wr_en), 64'd0);
    chk("rst_mt_din", mt_din, 64'd0);
    chk("rst_cmp_din", cmp_din, 64'd0);
    chk("rst_swint", 64'(sw_int), 64'd0);
    rst = 1'b0;
    idle(1);
    chk("rst_pending", 64'(pending), 64'd1);
    rd32(5'h08, 32'h0);
    idle(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/asrv32_timer_bridge.md
Name: asrv32_timer_bridge

Overview:
Memory-mapped responder on the core data bus that owns the machine timer and software-interrupt registers as seen by software. It turns 32-bit bus stores into 64-bit commit pulses on the CSR unit's timer write interface (mtime/mtimecmp wr_en and din). It keeps shadow copies of mtime and mtimecmp so bus loads return coherent values, and it drives the software-interrupt line into the CSR unit.

Parameters:
BASE_ADDR, 32'h8000_0000, bus base address of the register window (aligned to 32 bytes)
CLK_FREQ_MHZ, 100, core clock in MHz; the shadow mtime ticks once per (CLK_FREQ_MHZ*10**6)/1000 cycles, matching the CSR unit

Ports:
i_clk  input  1  core clock
i_rst  input  1  synchronous, active-high reset
i_stb  input  1  bus request strobe
i_we  input  1  1 = store, 0 = load
i_addr  input  32  byte address
i_wdata  input  32  store data
i_wsel  input  4  byte enables
o_ack  output  1  one-cycle response pulse
o_rdata  output  32  load data, valid with o_ack
o_mtime_wr_en  output  1  one-cycle pulse to CSR i_mtime_wr_en
o_mtimecmp_wr_en  output  1  one-cycle pulse to CSR i_mtimecmp_wr_en
o_mtime_din  output  64  value for CSR i_mtime_din
o_mtimecmp_din  output  64  value for CSR i_mtimecmp_din
o_software_interrupt  output  1  MSIP level to CSR i_software_interrupt
o_timer_pending  output  1  level: shadow mtime >= shadow mtimecmp

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high; i_rst sampled on the rising edge of i_clk.
- Window: hit when i_addr[31:5]==BASE_ADDR[31:5]. Offsets: 0x00 MSIP (bit0), 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 MTIME_LO, 0x14 MTIME_HI. Other offsets and misses are unmapped.
- Handshake: any i_stb is accepted in the cycle it is seen. o_ack is high exactly the next cycle, with o_rdata registered. Back-to-back strobes on consecutive cycles each get their own ack. No stall. Unmapped reads return 0; unmapped writes are acked and ignored.
- Reset: o_ack=0, o_rdata=0, both wr_en=0, both din=0, o_software_interrupt=0. Shadow mtime=0, shadow mtimecmp=0 (so o_timer_pending=1 after reset), millisec counter=0, lo-staging valid flags=0, read snapshot=0. A transaction in flight at reset is dropped with no ack.
- MSIP: a write with i_wsel[0] sets bit0 from i_wdata[0]. Reads return {31'b0,msip}. o_software_interrupt = msip register.
- 64-bit writes (same rule for MTIME and MTIMECMP, separate staging per register): only i_wsel==4'hF is honoured; partial writes are acked and ignored.
  - LO write: store into staging_lo and set staged=1. No pulse.
  - HI write: next cycle, wr_en pulses for one cycle with din={i_wdata, staged ? staging_lo : shadow[31:0]}. The shadow loads the same value in the same cycle, and staged clears.
  - wr_en and din update together. din holds its last value after the pulse.
- Shadow mtime: increments by 1 when the millisec counter wraps at MILLISEC_WRAP-1.
  - A commit to MTIME reloads shadow mtime and resets the millisec counter to 0. The CSR applies the same rule.
  - Commit and tick in the same cycle: commit wins and the tick is lost.
  - 64-bit wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 = 0.
- Reads:
  - MTIME_LO returns shadow[31:0] and latches shadow[63:32] into a snapshot.
  - MTIME_HI returns the snapshot if the previous accepted transaction was an MTIME_LO read; otherwise it returns live shadow[63:32].
  - MTIMECMP_LO/HI return the shadow directly.
  - Staged, uncommitted LO data is not visible to reads.
- o_timer_pending: combinational unsigned 64-bit compare of the shadows.

Test Plan:
- Reset then read 0x10/0x14/0x08 -> ack one cycle after each stb; data 0,0,0; o_timer_pending=1, o_software_interrupt=0.
- Write 0x08=32'h0000_1000, then 0x0C=32'h0000_0002 -> exactly one o_mtimecmp_wr_en pulse, one cycle after the HI stb; o_mtimecmp_din=64'h0000_0002_0000_1000; a read of 0x0C returns 2; o_timer_pending=0.
- Write 0x14=32'h5 with no prior LO write, shadow=64'h0000_0000_0000_0007 -> o_mtime_din=64'h0000_0005_0000_0007; a write with i_wsel=4'h3 to 0x10 -> ack, no pulse, no change.
- CLK_FREQ_MHZ=1: after an mtime commit of 64'h0000_0000_FFFF_FFFF, wait 1000 cycles -> LO read returns 0 and HI read returns 1. Repeat with the tick landing between the LO and HI reads -> HI still returns 0 (snapshot).
- Write 0x00 with wdata=1, wsel=4'h1 -> o_software_interrupt=1 next cycle. Write 0 -> clears. Write 1 with wsel=4'h2 -> unchanged.
- Strobes on 3 consecutive cycles (read 0x00, unmapped 0x1C, read 0x08) -> 3 consecutive acks with rdata msip, 0, cmp_lo. Assert i_rst during the second -> no further acks; all outputs at reset values.
